// File: rtl/hicore_icb_arb2_pkg.sv
// Shared widths and helpers for the two-master ICB arbiter.
`default_nettype none

`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif

package hicore_icb_arb2_pkg;
  localparam int HICORE_AW = `HiCore_ADDR_SIZE;
  localparam int HICORE_DW = `HiCore_REG_SIZE;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/gnrl_dfflr.sv
// Load-enabled DFF with asynchronous active-low reset to zero.
`default_nettype none

module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          lden_i,
  input  logic [DW-1:0] dnxt_i,
  output logic [DW-1:0] qout_o,
  input  logic          clk,
  input  logic          rst_n
);
  logic [DW-1:0] qout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      qout_q <= '0;
    else if (lden_i) qout_q <= dnxt_i;
  end

  assign qout_o = qout_q;
endmodule

`default_nettype wire

// File: rtl/gnrl_dffr.sv
// Plain DFF with asynchronous active-low reset to zero.
`default_nettype none

module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic [DW-1:0] dnxt_i,
  output logic [DW-1:0] qout_o,
  input  logic          clk,
  input  logic          rst_n
);
  logic [DW-1:0] qout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout_q <= '0;
    else        qout_q <= dnxt_i;
  end

  assign qout_o = qout_q;
endmodule

`default_nettype wire

// File: rtl/hicore_icb_id_fifo.sv
// DEPTH x 1-bit in-order FIFO holding the owner of each outstanding command.
`default_nettype none

module hicore_icb_id_fifo
  import hicore_icb_arb2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_q;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wptr_d = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_i  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
  end

  gnrl_dffr #(.DW(PW)) u_wptr (.dnxt_i(wptr_d), .qout_o(wptr_q), .clk(clk), .rst_n(rst_n));
  gnrl_dffr #(.DW(PW)) u_rptr (.dnxt_i(rptr_d), .qout_o(rptr_q), .clk(clk), .rst_n(rst_n));
  gnrl_dffr #(.DW(CW)) u_cnt  (.dnxt_i(cnt_d),  .qout_o(cnt_q),  .clk(clk), .rst_n(rst_n));

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    gnrl_dfflr #(.DW(1)) u_ent (
      .lden_i (push_i && (wptr_q == PW'(i))),
      .dnxt_i (din_i),
      .qout_o (mem_q[i]),
      .clk    (clk),
      .rst_n  (rst_n)
    );
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

`default_nettype wire

// File: rtl/hicore_icb_arb2.sv
// Round-robin two-master to one-slave ICB arbiter with stall lock and in-order
// response routing.
`default_nettype none

module hicore_icb_arb2
  import hicore_icb_arb2_pkg::*;
#(
  parameter int AW   = HICORE_AW,
  parameter int DW   = HICORE_DW,
  parameter int OUTS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic            s_icb_cmd_read,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata
);
  logic lock_q, lock_d, lock_id_q, lock_id_d, last_q, last_d;
  logic cand_id, cand_valid, cmd_ok, cmd_hs, rsp_hs;
  logic fifo_full, fifo_empty, fifo_head;
  logic own0, own1;

  // last_q resets to m0, so a lone m0 wins but simultaneous requests go to m1.
  always_comb begin
    cand_id = 1'b0;
    if (lock_q)                                     cand_id = lock_id_q;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid)  cand_id = ~last_q;
    else if (m1_icb_cmd_valid)                      cand_id = 1'b1;
  end

  assign cand_valid = cand_id ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign cmd_ok     = ~fifo_full;

  assign s_icb_cmd_valid  = cand_valid & cmd_ok;
  assign s_icb_cmd_read   = cand_id ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_addr   = cand_id ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_wdata  = cand_id ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask  = cand_id ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign m0_icb_cmd_ready = ~cand_id & s_icb_cmd_ready & cmd_ok;
  assign m1_icb_cmd_ready =  cand_id & s_icb_cmd_ready & cmd_ok;
  assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    if (cmd_hs) begin
      lock_d = 1'b0;
      last_d = cand_id;
    end else if (s_icb_cmd_valid) begin
      lock_d    = 1'b1;
      lock_id_d = cand_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

  hicore_icb_id_fifo #(.DEPTH(OUTS)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_hs),
    .din_i   (cand_id),
    .pop_i   (rsp_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // With nothing outstanding neither master owns the response channel.
  assign own0 = ~fifo_empty & ~fifo_head;
  assign own1 = ~fifo_empty &  fifo_head;

  assign s_icb_rsp_ready  = (fifo_head ? m1_icb_rsp_ready : m0_icb_rsp_ready) & ~fifo_empty;
  assign rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready;
  assign m0_icb_rsp_valid = s_icb_rsp_valid & own0;
  assign m1_icb_rsp_valid = s_icb_rsp_valid & own1;
  assign m0_icb_rsp_err   = s_icb_rsp_err & own0;
  assign m1_icb_rsp_err   = s_icb_rsp_err & own1;
  assign m0_icb_rsp_rdata = own0 ? s_icb_rsp_rdata : '0;
  assign m1_icb_rsp_rdata = own1 ? s_icb_rsp_rdata : '0;
endmodule

`default_nettype wire

// File: tb/tb_hicore_icb_arb2.sv
// Directed self-checking bench for hicore_icb_arb2.
`default_nettype none

module tb_hicore_icb_arb2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_cv, m0_cr, m0_rd, m0_rv, m0_rr, m0_re;
  logic m1_cv, m1_cr, m1_rd, m1_rv, m1_rr, m1_re;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata, s_rdata;
  logic [DW/8-1:0] m0_wmask, m1_wmask, s_wmask;
  logic s_cv, s_cr, s_rd, s_rv, s_rr, s_re;

  int n_chk = 0;
  int n_pass = 0;
  int g0, g1;

  always #5 clk = ~clk;

  hicore_icb_arb2 #(.AW(AW), .DW(DW), .OUTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_cv), .m0_icb_cmd_ready(m0_cr), .m0_icb_cmd_read(m0_rd),
    .m0_icb_cmd_addr(m0_addr), .m0_icb_cmd_wdata(m0_wdata), .m0_icb_cmd_wmask(m0_wmask),
    .m0_icb_rsp_valid(m0_rv), .m0_icb_rsp_ready(m0_rr), .m0_icb_rsp_err(m0_re),
    .m0_icb_rsp_rdata(m0_rdata),
    .m1_icb_cmd_valid(m1_cv), .m1_icb_cmd_ready(m1_cr), .m1_icb_cmd_read(m1_rd),
    .m1_icb_cmd_addr(m1_addr), .m1_icb_cmd_wdata(m1_wdata), .m1_icb_cmd_wmask(m1_wmask),
    .m1_icb_rsp_valid(m1_rv), .m1_icb_rsp_ready(m1_rr), .m1_icb_rsp_err(m1_re),
    .m1_icb_rsp_rdata(m1_rdata),
    .s_icb_cmd_valid(s_cv), .s_icb_cmd_ready(s_cr), .s_icb_cmd_read(s_rd),
    .s_icb_cmd_addr(s_addr), .s_icb_cmd_wdata(s_wdata), .s_icb_cmd_wmask(s_wmask),
    .s_icb_rsp_valid(s_rv), .s_icb_rsp_ready(s_rr), .s_icb_rsp_err(s_re),
    .s_icb_rsp_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear();
    m0_cv = 0; m0_rd = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rr = 0;
    m1_cv = 0; m1_rd = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rr = 0;
    s_cr = 0; s_rv = 0; s_re = 0; s_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear();
    rst_n = 0;
    s_rv = 1; s_rdata = 32'hFFFF_FFFF; m0_rr = 1; m1_rr = 1;
    #1;
    chk("rst_s_cmd_valid", s_cv, 0);
    chk("rst_m0_cmd_ready", m0_cr, 0);
    chk("rst_m1_cmd_ready", m1_cr, 0);
    chk("rst_s_rsp_ready", s_rr, 0);
    chk("rst_m0_rsp_valid", m0_rv, 0);
    chk("rst_m0_rsp_rdata", m0_rdata, 0);
    chk("rst_m1_rsp_rdata", m1_rdata, 0);
    step(); step();
    rst_n = 1;
    clear();
    step();

    // Single m0 read, response one cycle later.
    m0_cv = 1; m0_rd = 1; m0_addr = 32'h0200_BFF8; s_cr = 1; m0_rr = 1; #1;
    chk("t1_s_cmd_valid", s_cv, 1);
    chk("t1_s_cmd_addr", s_addr, 32'h0200_BFF8);
    chk("t1_s_cmd_read", s_rd, 1);
    chk("t1_m0_cmd_ready", m0_cr, 1);
    step();
    m0_cv = 0; s_rv = 1; s_rdata = 32'h1234; #1;
    chk("t1_m0_rsp_valid", m0_rv, 1);
    chk("t1_m0_rsp_rdata", m0_rdata, 32'h1234);
    chk("t1_m1_rsp_valid", m1_rv, 0);
    chk("t1_s_rsp_ready", s_rr, 1);
    step();
    #1;
    chk("t1_empty_s_rsp_ready", s_rr, 0);
    chk("t1_empty_m0_rsp_valid", m0_rv, 0);
    clear(); step();

    // Both masters request continuously: grants alternate starting with m1.
    g0 = 0; g1 = 0;
    m0_cv = 1; m0_rd = 1; m0_addr = 32'h100;
    m1_cv = 1; m1_rd = 1; m1_addr = 32'h200;
    s_cr = 1; s_rv = 1; m0_rr = 1; m1_rr = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t2_addr_%0d", k), s_addr, (k % 2 == 0) ? 32'h200 : 32'h100);
      if (m0_cr) g0++;
      if (m1_cr) g1++;
      step();
    end
    chk("t2_m0_grants", g0, 4);
    chk("t2_m1_grants", g1, 4);
    m0_cv = 0; m1_cv = 0; #1;
    chk("t2_drain_m0_rsp_valid", m0_rv, 1);
    chk("t2_drain_m1_rsp_valid", m1_rv, 0);
    step();
    clear(); step();

    // m0 write then m1 read; m0's error response completes alongside m1's command.
    m0_cv = 1; m0_rd = 0; m0_addr = 32'h10; m0_wdata = 32'hDEAD; m0_wmask = 4'hF;
    s_cr = 1; m0_rr = 1; m1_rr = 1; #1;
    chk("t5_s_cmd_read", s_rd, 0);
    chk("t5_s_cmd_wdata", s_wdata, 32'hDEAD);
    chk("t5_s_cmd_wmask", s_wmask, 4'hF);
    step();
    m0_cv = 0; m1_cv = 1; m1_rd = 1; m1_addr = 32'h20;
    s_rv = 1; s_re = 1; s_rdata = '0; #1;
    chk("t5_m1_cmd_ready", m1_cr, 1);
    chk("t5_s_cmd_addr", s_addr, 32'h20);
    chk("t5_m0_rsp_valid", m0_rv, 1);
    chk("t5_m0_rsp_err", m0_re, 1);
    chk("t5_m1_rsp_valid_a", m1_rv, 0);
    chk("t5_m1_rsp_err_a", m1_re, 0);
    step();
    m1_cv = 0; s_re = 0; s_rdata = 32'hA5A5; #1;
    chk("t5_m1_rsp_valid", m1_rv, 1);
    chk("t5_m1_rsp_rdata", m1_rdata, 32'hA5A5);
    chk("t5_m1_rsp_err", m1_re, 0);
    chk("t5_m0_rsp_rdata", m0_rdata, 0);
    step();
    clear(); step();

    // m1 stalls; m0 joins but the lock holds m1 until its handshake.
    m1_cv = 1; m1_rd = 1; m1_addr = 32'h300; s_cr = 0; #1;
    chk("t3_addr_c0", s_addr, 32'h300);
    chk("t3_m1_ready_c0", m1_cr, 0);
    step();
    m0_cv = 1; m0_rd = 1; m0_addr = 32'h100;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk($sformatf("t3_addr_c%0d", k), s_addr, 32'h300);
      chk($sformatf("t3_m0_ready_c%0d", k), m0_cr, 0);
      step();
    end
    s_cr = 1; #1;
    chk("t3_m1_granted", m1_cr, 1);
    chk("t3_m0_not_granted", m0_cr, 0);
    step();
    m1_cv = 0; #1;
    chk("t3_m0_addr", s_addr, 32'h100);
    chk("t3_m0_granted", m0_cr, 1);
    step();
    m0_cv = 0; s_cr = 0; s_rv = 1; m0_rr = 1; m1_rr = 1; #1;
    chk("t3_rsp_to_m1", m1_rv, 1);
    step();
    #1;
    chk("t3_rsp_to_m0", m0_rv, 1);
    step();
    clear(); step();

    // Outstanding limit: third command waits for a pop, accepted the cycle after.
    m0_cv = 1; m0_rd = 1; m0_addr = 32'h40; s_cr = 1; #1;
    chk("t4_cmd1_ready", m0_cr, 1);
    step(); #1;
    chk("t4_cmd2_ready", m0_cr, 1);
    step(); #1;
    chk("t4_full_ready", m0_cr, 0);
    chk("t4_full_s_valid", s_cv, 0);
    step();
    s_rv = 1; m0_rr = 1; #1;
    chk("t4_pop_s_rsp_ready", s_rr, 1);
    chk("t4_no_bypass", m0_cr, 0);
    step();
    s_rv = 0; #1;
    chk("t4_resume_ready", m0_cr, 1);
    step();

    // Reset with two outstanding commands.
    clear();
    rst_n = 0;
    step();
    rst_n = 1;
    s_rv = 1; s_rdata = 32'h55; m0_rr = 1; m1_rr = 1; #1;
    chk("t6_s_rsp_ready", s_rr, 0);
    chk("t6_m0_rsp_valid", m0_rv, 0);
    chk("t6_m1_rsp_valid", m1_rv, 0);
    step();
    s_rv = 0; m0_cv = 1; m0_addr = 32'h80; s_cr = 1; #1;
    chk("t6_m0_granted", m0_cr, 1);
    chk("t6_s_cmd_addr", s_addr, 32'h80);
    step();
    clear(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/hicore_icb_arb2.md
Name: hicore_icb_arb2

Overview:
- Two-master to one-slave ICB arbiter that shares the CLINT/peripheral ICB port between the core LSU (m0) and the debug/DMA master (m1).
- Round-robin grant with grant lock while a command is stalled.
- A small in-order ID FIFO records which master owns each outstanding command, and routes each slave response back to that owner.
- Sits between the core's bus splitter and the CLINT slave port.

Parameters:
- AW, `HiCore_ADDR_SIZE (32): address width.
- DW, `HiCore_REG_SIZE (32): data width; wmask width is DW/8.
- OUTS, 2: maximum outstanding commands (1..8); sets ID FIFO depth.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_icb_cmd_valid/ready/read  in/out/in  1 each  master N command handshake and read flag, N = 0,1
- mN_icb_cmd_addr  in  AW  master N address
- mN_icb_cmd_wdata  in  DW  master N write data
- mN_icb_cmd_wmask  in  DW/8  master N byte mask
- mN_icb_rsp_valid/ready/err  out/in/out  1 each  master N response handshake and error flag
- mN_icb_rsp_rdata  out  DW  master N read data
- s_icb_cmd_*  out (ready in)  same widths  slave command
- s_icb_rsp_*  in (ready out)  same widths  slave response

Behaviour:
- Reset values:
  - grant pointer = m0 preferred.
  - lock = 0.
  - FIFO empty, count = 0.
  - All valid/ready outputs are 0 while no request is present.
  - All rsp data outputs are 0.
- cmd_ok = (count < OUTS).
- Arbitration is combinational with zero added latency. Candidate selection:
  - If lock is set, the locked master.
  - Else, if both valid, the master that was not granted last.
  - Else, the single valid master.
- Command datapath to the slave:
  - s_cmd_valid = cand_valid & cmd_ok.
  - The candidate's cmd fields are muxed onto s_cmd_*.
  - cand cmd_ready = s_cmd_ready & cmd_ok.
  - The non-candidate's cmd_ready is 0.
- Lock register:
  - Set when s_cmd_valid & ~s_cmd_ready; this holds ICB valid-stability and prevents grant switching mid-stall.
  - Cleared on command handshake.
- Round-robin pointer updates only on command handshake.
- On command handshake, the owner ID (1 bit) is pushed into the FIFO.
- Response routing:
  - The FIFO head selects the owner.
  - owner rsp_valid = s_rsp_valid & ~empty; other master's rsp_valid = 0.
  - s_rsp_ready = owner rsp_ready & ~empty.
  - rdata and err go only to the owner; the other master sees 0.
- On response handshake, the FIFO pops.
- Counter and FIFO rules:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full (count == OUTS): no new command is accepted; a pop in the same cycle does not bypass, so acceptance resumes the next cycle.
  - Empty: s_rsp_ready = 0; a slave response arriving with no outstanding command is stalled, never misrouted.
  - Pointers are log2(OUTS) bits (minimum 1) and wrap modulo OUTS; count is log2(OUTS)+1 bits.
- Same-cycle command and response: a response may return in the cycle after its command. A command and an unrelated response may complete in the same cycle.
- Reset mid-transaction clears lock, FIFO and pointer. In-flight slave responses after reset are stalled (FIFO empty).

Decomposition:
- AW/DW defaults come from the existing `HiCore_ADDR_SIZE / `HiCore_REG_SIZE defines in config.v; no new package types.
- One sub-module: hicore_icb_id_fifo. It is a parameterised DEPTH x 1-bit synchronous FIFO with push/pop/full/empty/head, built on the gnrl_dfflr/gnrl_dffr flops.

Test Plan:
- m0 read of addr 0x0200BFF8, slave rsp 0x1234 one cycle later -> m0 rsp_rdata = 0x1234, m1 rsp_valid never asserts, count returns to 0.
- m0 and m1 both valid every cycle, slave always ready, 8 cycles -> grants alternate m1, m0, m1, ... (pointer reset favours m0 first only when alone); each master gets 4 handshakes.
- m1 valid, s_cmd_ready = 0 for 3 cycles while m0 also raises valid -> s_cmd_addr stays m1's address; m1 is granted on ready; m0 is granted the next cycle.
- OUTS = 2, slave withholds responses, m0 issues 3 commands -> third command has cmd_ready = 0 until one response handshake; accepted the cycle after the pop.
- Interleaved m0 write, m1 read, slave rsp err = 1 then rdata 0xA5A5 -> m0 receives err = 1, m1 receives 0xA5A5 with err = 0, in issue order.
- Assert rst_n low with 2 outstanding commands, then release and drive a slave rsp_valid -> s_rsp_ready = 0, no master rsp_valid, next command is granted to m0.
